// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_NINTH,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic       ferr;
    logic       bit9;
    logic [7:0] data;
  } rx_entry_t;

  // Oversample points within a 16-tick bit cell.
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;
  localparam logic [3:0] CNT_LAST = 4'd15;
  localparam logic [2:0] LAST_BIT = 3'd7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// RCREG-side bus of the receiver: pop request in, head entry and status out.
interface uart_rx_if;
  logic       rcreg_rd_en;
  logic [7:0] rcreg_out;
  logic       rx9d_out;
  logic       ferr_out;
  logic       oerr_out;
  logic       rcif;
  logic       rx_busy;

  modport master (
    output rcreg_rd_en,
    input  rcreg_out, rx9d_out, ferr_out, oerr_out, rcif, rx_busy
  );

  modport slave (
    input  rcreg_rd_en,
    output rcreg_out, rx9d_out, ferr_out, oerr_out, rcif, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; head is always visible, pop on empty is ignored,
// a push into a full FIFO only lands when a pop happens on the same edge.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rx_entry_t wr_entry,
  output logic      full,
  output logic      empty,
  output rx_entry_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rx_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_pop;
  logic            do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// PIC16F-style asynchronous receiver: synchroniser, 16x oversampling
// frame FSM with 3-sample majority vote, and a 2-entry receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_pin,
  input  logic     spen,
  input  logic     cren,
  input  logic     rx9,
  input  logic     uart_rx_async_div16_en,
  uart_rx_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   tick;
  rx_state_t              state;
  logic [3:0]             cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   s_a;
  logic                   s_b;
  logic                   bit9_q;
  logic                   maj;
  logic                   push_q;
  rx_entry_t              push_entry;
  logic                   busy_q;
  logic                   oerr_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  rx_entry_t              fifo_head;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign tick = uart_rx_async_div16_en;
  assign maj  = maj3(s_a, s_b, rxs);

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
  end

  // Frame FSM: oversample counter, bit shifter and registered push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      bit9_q     <= 1'b0;
      push_q     <= 1'b0;
      push_entry <= '0;
      busy_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (!spen || !cren) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else if (tick) begin
        if (state != ST_IDLE) begin
          if (cnt == SAMPLE_A) s_a <= rxs;
          if (cnt == SAMPLE_B) s_b <= rxs;
        end
        unique case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (!rxs && !oerr_q) begin
              state  <= ST_START;
              cnt    <= 4'd1;
              bit9_q <= 1'b0;
              busy_q <= 1'b1;
            end
          end
          ST_START: begin
            cnt <= cnt + 4'd1;
            if (cnt == SAMPLE_C && maj) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            cnt <= cnt + 4'd1;
            if (cnt == SAMPLE_C) shreg <= {maj, shreg[7:1]};
            if (cnt == CNT_LAST) begin
              // rx9 is only consulted here, so mid-frame changes apply at bit 7's end.
              if (bit_idx == LAST_BIT) state <= rx9 ? ST_NINTH : ST_STOP;
              else                     bit_idx <= bit_idx + 3'd1;
            end
          end
          ST_NINTH: begin
            cnt <= cnt + 4'd1;
            if (cnt == SAMPLE_C) bit9_q <= maj;
            if (cnt == CNT_LAST) state <= ST_STOP;
          end
          ST_STOP: begin
            cnt <= cnt + 4'd1;
            if (cnt == SAMPLE_C) begin
              push_q     <= 1'b1;
              push_entry <= '{ferr: ~maj, bit9: bit9_q, data: shreg};
              state      <= ST_IDLE;
              cnt        <= '0;
              busy_q     <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky overrun: a push that finds the FIFO full with no pop alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         oerr_q <= 1'b0;
    else if (!cren)                                   oerr_q <= 1'b0;
    else if (push_q && fifo_full && !bus.rcreg_rd_en) oerr_q <= 1'b1;
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .pop      (bus.rcreg_rd_en),
    .wr_entry (push_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign bus.rcreg_out = fifo_head.data;
  assign bus.rx9d_out  = fifo_head.bit9;
  assign bus.ferr_out  = fifo_head.ferr;
  assign bus.oerr_out  = oerr_q;
  assign bus.rcif      = ~fifo_empty;
  assign bus.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks, 64 clocks per bit.
module tb_uart_rx;

  logic clk;
  logic rst;
  logic rx_pin;
  logic spen;
  logic cren;
  logic rx9;
  logic tick;

  int errors = 0;
  int checks = 0;
  logic busy_seen;

  uart_rx_if rxif();

  uart_rx #(.FIFO_DEPTH(2), .SYNC_STAGES(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rx_pin                 (rx_pin),
    .spen                   (spen),
    .cren                   (cren),
    .rx9                    (rx9),
    .uart_rx_async_div16_en (tick),
    .bus                    (rxif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       ninth;
    logic       mode9;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_9;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rxif.rx_busy) busy_seen = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic ninth, input logic with9,
                            input logic stop_lvl);
    rx_pin = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_clks(64);
    end
    if (with9) begin
      rx_pin = ninth;
      wait_clks(64);
    end
    rx_pin = stop_lvl;
  endtask

  // Wait for the stop-sample edge (rx_busy falls), then release the line.
  task automatic finish_frame(input logic check_edge, input logic pop_at_push);
    int n = 0;
    while (rxif.rx_busy && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("busy_cleared_at_stop", rxif.rx_busy, 0);
    rx_pin = 1'b1;
    if (pop_at_push) rxif.rcreg_rd_en = 1'b1;
    if (check_edge) check("rcif_at_push_edge", rxif.rcif, 0);
    @(negedge clk);
    rxif.rcreg_rd_en = 1'b0;
    if (check_edge) check("rcif_one_cycle_later", rxif.rcif, 1);
    wait_clks(16);
  endtask

  task automatic pop();
    rxif.rcreg_rd_en = 1'b1;
    @(negedge clk);
    rxif.rcreg_rd_en = 1'b0;
    wait_clks(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rcreg"}, rxif.rcreg_out, 8'h00);
    check({tag, "_rx9d"},  rxif.rx9d_out, 0);
    check({tag, "_ferr"},  rxif.ferr_out, 0);
    check({tag, "_oerr"},  rxif.oerr_out, 0);
    check({tag, "_rcif"},  rxif.rcif, 0);
    check({tag, "_busy"},  rxif.rx_busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1};
    vecs[2] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'hE1, 1'b1, 1'b1, 1'b0, 8'hE1, 1'b1, 1'b1};

    rst = 1'b0;
    rx_pin = 1'b1;
    spen = 1'b1;
    cren = 1'b1;
    rx9 = 1'b0;
    rxif.rcreg_rd_en = 1'b0;
    busy_seen = 1'b0;
    wait_clks(5);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clks(8);

    // Pop on empty is ignored.
    pop();
    check("empty_pop_rcif", rxif.rcif, 0);
    check("empty_pop_head", rxif.rcreg_out, 8'h00);

    // Two-tick low glitch: false start.
    busy_seen = 1'b0;
    rx_pin = 1'b0;
    wait_clks(8);
    rx_pin = 1'b1;
    wait_clks(72);
    check("glitch_busy_pulsed", busy_seen, 1);
    check("glitch_busy_back", rxif.rx_busy, 0);
    check("glitch_rcif", rxif.rcif, 0);

    // spen=0 aborts a frame in progress.
    rx_pin = 1'b0;
    wait_clks(150);
    check("spen_frame_busy", rxif.rx_busy, 1);
    spen = 1'b0;
    rx_pin = 1'b1;
    wait_clks(2);
    check("spen_abort_busy", rxif.rx_busy, 0);
    wait_clks(4);
    spen = 1'b1;
    wait_clks(40);
    check("spen_abort_rcif", rxif.rcif, 0);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      rx9 = vecs[i].mode9;
      send_frame(vecs[i].data, vecs[i].ninth, vecs[i].mode9, vecs[i].stop);
      finish_frame(1'b1, 1'b0);
      check($sformatf("vec%0d_data", i), rxif.rcreg_out, vecs[i].exp_data);
      check($sformatf("vec%0d_rx9d", i), rxif.rx9d_out, vecs[i].exp_9);
      check($sformatf("vec%0d_ferr", i), rxif.ferr_out, vecs[i].exp_ferr);
      check($sformatf("vec%0d_oerr", i), rxif.oerr_out, 0);
      pop();
      check($sformatf("vec%0d_rcif_after_pop", i), rxif.rcif, 0);
    end
    rx9 = 1'b0;

    // Push into full FIFO with a pop on the same edge: no overrun.
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b1, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b0, 1'b0);
    send_frame(8'hCC, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b0, 1'b1);
    check("simul_oerr", rxif.oerr_out, 0);
    check("simul_head", rxif.rcreg_out, 8'hBB);
    pop();
    check("simul_head2", rxif.rcreg_out, 8'hCC);
    pop();
    check("simul_empty", rxif.rcif, 0);

    // Overrun: third frame dropped, fourth not even started.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b0, 1'b0);
    check("ovr_oerr", rxif.oerr_out, 1);
    check("ovr_head", rxif.rcreg_out, 8'h11);
    busy_seen = 1'b0;
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    wait_clks(64);
    check("ovr_ignored_busy", busy_seen, 0);
    check("ovr_ignored_head", rxif.rcreg_out, 8'h11);
    check("ovr_oerr_still", rxif.oerr_out, 1);
    cren = 1'b0;
    wait_clks(2);
    check("cren_clears_oerr", rxif.oerr_out, 0);
    cren = 1'b1;
    wait_clks(2);
    check("cren_fifo_kept", rxif.rcreg_out, 8'h11);
    pop();
    check("ovr_pop_head", rxif.rcreg_out, 8'h22);
    check("ovr_pop_rcif", rxif.rcif, 1);
    pop();
    check("ovr_pop_empty", rxif.rcif, 0);

    // Asynchronous reset during DATA with a stored entry.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b1, 1'b0);
    check("pre_reset_head", rxif.rcreg_out, 8'h3C);
    rx_pin = 1'b0;
    wait_clks(64 + 3 * 64);
    rx_pin = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk);
    wait_clks(4);
    rst = 1'b1;
    wait_clks(8);
    check("post_reset_busy", rxif.rx_busy, 0);
    send_frame(8'hC4, 1'b0, 1'b0, 1'b1);
    finish_frame(1'b1, 1'b0);
    check("post_reset_data", rxif.rcreg_out, 8'hC4);
    check("post_reset_rx9d", rxif.rx9d_out, 0);
    check("post_reset_ferr", rxif.ferr_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, receive FIFO entries (fixed at 2 for PIC16F compatibility).
REQ-002 Parameter: SYNC_STAGES, 2, rx_pin synchroniser flops.
REQ-003 clk  input  1  system clock (Fosc); all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_pin  input  1  asynchronous serial line, idle high.
REQ-006 spen, cren, rx9  input  1 each  RCSTA enables: serial port, continuous receive, 9-bit mode.
REQ-007 uart_rx_async_div16_en  input  1  one-cycle tick at 16x baud from uart_spbrg.
REQ-008 rcreg_rd_en  input  1  one-cycle pop request (RCREG read).
REQ-009 rcreg_out  output  8  FIFO head data.
REQ-010 rx9d_out, ferr_out  output  1 each  FIFO head 9th bit and framing-error flag.
REQ-011 oerr_out  output  1  overrun error, sticky.
REQ-012 rcif  output  1  FIFO non-empty.
REQ-013 rx_busy  output  1  state != IDLE.

Function
REQ-014 rx_pin SHALL pass through SYNC_STAGES flops; all logic uses the synchronised value rxs.
REQ-015 States: IDLE, START, DATA, NINTH, STOP; all counters and states advance only on clock edges where the tick is high.
REQ-016 4-bit tick counter cnt; samples SHALL be taken on ticks where cnt is 7, 8, 9; bit value is the majority of the three samples.
REQ-017 IDLE: on a tick with rxs=0, spen=1, cren=1, oerr=0 -> START, cnt=1.
REQ-018 START: majority 1 at cnt 9 -> IDLE (false start, nothing pushed); otherwise on tick at cnt 15 -> DATA, cnt=0, bit index 0.
REQ-019 DATA: 8 bits, LSB first, shifted at cnt 9; after bit 7 ends (cnt 15) -> NINTH if rx9=1, else STOP.
REQ-020 NINTH: bit sampled at cnt 9 into bit9; at cnt 15 -> STOP.
REQ-021 STOP: at cnt 9 the frame {ferr = NOT majority, bit9, data} SHALL be pushed and the state SHALL return to IDLE on the same edge (no wait for cnt 15).
REQ-022 In 8-bit mode the pushed bit9 SHALL be 0.
REQ-023 rcif SHALL rise on the clock edge immediately following the stop-sample tick edge (1-cycle latency from push).
REQ-024 Push when FIFO full (after accounting for a same-cycle pop) SHALL drop the frame and set oerr; while oerr=1 no new start is accepted.
REQ-025 Simultaneous push and pop: pop first, push then succeeds; no oerr.
REQ-026 Pop when empty SHALL be ignored; head outputs hold their values.
REQ-027 rcreg_out, rx9d_out, ferr_out SHALL always reflect the head entry; after a pop they show the next entry on the following cycle.
REQ-028 cren=0 SHALL clear oerr and abort any frame (state IDLE, cnt 0); FIFO contents retained.
REQ-029 spen=0 SHALL abort any frame identically; oerr and FIFO retained.
REQ-030 rx9 changes mid-frame take effect at the end of bit 7.

Reset
REQ-031 rst=0 SHALL asynchronously force: state IDLE, cnt 0, synchroniser flops 1, FIFO empty, oerr 0.
REQ-032 Reset output values: rcreg_out 0x00, rx9d_out 0, ferr_out 0, oerr_out 0, rcif 0, rx_busy 0.
REQ-033 Reset mid-frame SHALL discard the partial frame without any push.

Structure
REQ-034 Package uart_pkg SHALL hold the state enum, the frame-entry struct {ferr, bit9, data[7:0]}, and constants SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9.
REQ-035 The FIFO SHALL be sub-module uart_rx_fifo (push, pop, full, empty, head); the FSM, synchroniser and shifter stay in uart_rx.

Verification (tick every 4 clk, 10 ns clk, bit = 640 ns)
REQ-036 Frame 0x55, valid stop, rx9=0 -> rcif=1 one cycle after the stop sample tick, rcreg_out=0x55, ferr_out=0.
REQ-037 Low glitch of 2 ticks in IDLE -> return to IDLE, rcif stays 0, rx_busy pulses then 0.
REQ-038 Frame 0xA3 with stop bit low -> rcreg_out=0xA3, ferr_out=1.
REQ-039 Three frames 0x11, 0x22, 0x33 with no reads -> oerr_out=1, FIFO holds 0x11, 0x22; a fourth frame is ignored; cren 1->0->1 clears oerr; pop -> 0x22 at head.
REQ-040 rx9=1, frame 0x7E with 9th bit 1 -> rcreg_out=0x7E, rx9d_out=1.
REQ-041 rst asserted during DATA -> all outputs at reset values; next full frame 0xC4 received correctly.
